// File: rtl/rob_arb_pkg.sv
// Purpose: shared types and constants for the reorder-buffer port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rob_arb_pkg;

  // Default global/local ID width. The ownership entry's local-ID field is
  // sized from it, so keep it in step with the arbiter's ID_WIDTH.
  localparam int ID_WIDTH_DEF = 4;

  // Owner field wide enough for the largest supported port count (8).
  localparam int OWNER_W = 3;

  // One ownership-table entry: which requester owns a global ID and the
  // local ID it used on AR, so R beats can be returned under that ID.
  typedef struct packed {
    logic                    valid;
    logic [OWNER_W-1:0]      owner;
    logic [ID_WIDTH_DEF-1:0] local_id;
  } rob_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin arbiter; searches req starting at a rotating pointer.
// Latency: grant is combinational from req; pointer moves on the next edge.
// Backpressure: pointer advances only when advance=1 (grant accepted).
//
// Ports: req (N requests), advance (grant consumed this cycle),
//        grant (one-hot), grant_idx (binary index), grant_vld (any grant).
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_vld
);

  logic [PW-1:0] ptr;
  logic [PW:0]   cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      // Candidate index (ptr + i) mod N without a divider.
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
      if (!grant_vld && req[cand[PW-1:0]]) begin
        grant_vld              = 1'b1;
        grant[cand[PW-1:0]]    = 1'b1;
        grant_idx              = cand[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == PW'(N-1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rob_port_arbiter.sv
// Purpose: shares one reorder_buffer among N_PORTS read requesters via ID remap.
// Latency: AR 1 cycle (registered); R 0 cycles (combinational routing).
// Backpressure: AR stalls on m_arready_i or full table; R ready follows owner.
//
// Ports: s_ar* / s_r*  requester-side AR and R channels, packed per port;
//        m_ar* / m_r*  reorder_buffer slave-side AR and R channels;
//        outstanding_o allocated entry count; err_unknown_id_o pulse when an
//        R beat arrives for an unallocated global ID (beat is dropped).
module rob_port_arbiter
  import rob_arb_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = ID_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_PORTS*ID_WIDTH-1:0]   s_arid_i,
  input  logic [N_PORTS-1:0]            s_arvalid_i,
  output logic [N_PORTS-1:0]            s_arready_o,
  output logic [N_PORTS*DATA_WIDTH-1:0] s_rdata_o,
  output logic [N_PORTS*ID_WIDTH-1:0]   s_rid_o,
  output logic [N_PORTS-1:0]            s_rvalid_o,
  input  logic [N_PORTS-1:0]            s_rready_i,
  output logic [ID_WIDTH-1:0]           m_arid_o,
  output logic                          m_arvalid_o,
  input  logic                          m_arready_i,
  input  logic [DATA_WIDTH-1:0]         m_rdata_i,
  input  logic [ID_WIDTH-1:0]           m_rid_i,
  input  logic                          m_rvalid_i,
  output logic                          m_rready_o,
  output logic [ID_WIDTH:0]             outstanding_o,
  output logic                          err_unknown_id_o
);

  localparam int DEPTH = 2**ID_WIDTH;
  localparam int PW    = $clog2(N_PORTS);

  rob_entry_t tbl [DEPTH];

  logic                load_en;
  logic                free_avail;
  logic [ID_WIDTH-1:0] free_id;
  logic [N_PORTS-1:0]  grant;
  logic [PW-1:0]       grant_idx;
  logic                grant_vld;
  logic                ar_hs;
  logic [ID_WIDTH-1:0] gnt_lid;

  rob_entry_t          ent;
  logic [N_PORTS-1:0]  owner_oh;
  logic                owner_rdy;
  logic                hit;
  logic                r_free;

  // ---------------- AR path ----------------
  assign load_en = !m_arvalid_o || m_arready_i;

  // Lowest free entry, from the registered table: an entry freed this cycle
  // only becomes allocatable from the next cycle on.
  always_comb begin
    free_avail = 1'b0;
    free_id    = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!tbl[i].valid) begin
        free_avail = 1'b1;
        free_id    = ID_WIDTH'(i);
      end
    end
  end

  rr_arbiter #(.N(N_PORTS)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (s_arvalid_i),
    .advance   (ar_hs),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign s_arready_o = grant & {N_PORTS{load_en && free_avail}};
  assign ar_hs       = grant_vld && load_en && free_avail;
  assign gnt_lid     = s_arid_i[grant_idx*ID_WIDTH +: ID_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_arvalid_o <= 1'b0;
      m_arid_o    <= '0;
    end else if (load_en) begin
      m_arvalid_o <= ar_hs;
      if (ar_hs) m_arid_o <= free_id;
    end
  end

  // ---------------- R path ----------------
  assign ent = tbl[m_rid_i];

  always_comb begin
    owner_oh = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      owner_oh[p] = (ent.owner == OWNER_W'(p));
    end
  end

  assign owner_rdy  = |(owner_oh & s_rready_i);
  assign hit        = m_rvalid_i && ent.valid;
  assign s_rvalid_o = hit ? owner_oh : '0;
  // Beats for unallocated IDs are accepted and dropped so the buffer never
  // wedges on them.
  assign m_rready_o = m_rvalid_i && (!ent.valid || owner_rdy);
  assign r_free     = hit && owner_rdy;
  assign s_rid_o    = {N_PORTS{ID_WIDTH'(ent.local_id)}};
  assign s_rdata_o  = {N_PORTS{m_rdata_i}};

  // ---------------- ownership table / counters ----------------
  // Alloc always targets an invalid entry and free a valid one, so the two
  // writes never collide on the same index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ar_hs && free_id == ID_WIDTH'(i)) begin
          tbl[i] <= '{valid: 1'b1, owner: OWNER_W'(grant_idx),
                      local_id: ID_WIDTH_DEF'(gnt_lid)};
        end else if (r_free && m_rid_i == ID_WIDTH'(i)) begin
          tbl[i].valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_o    <= '0;
      err_unknown_id_o <= 1'b0;
    end else begin
      outstanding_o    <= outstanding_o + {{ID_WIDTH{1'b0}}, ar_hs}
                                        - {{ID_WIDTH{1'b0}}, r_free};
      err_unknown_id_o <= m_rvalid_i && !ent.valid;
    end
  end

endmodule

// File: tb/tb_rob_port_arbiter.sv
// Purpose: directed self-checking bench for rob_port_arbiter.
// Latency: n/a.
// Backpressure: n/a.
module tb_rob_port_arbiter;

  localparam int N = 4;
  localparam int D = 8;
  localparam int I = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*I-1:0] s_arid_i;
  logic [N-1:0]   s_arvalid_i;
  logic [N-1:0]   s_arready_o;
  logic [N*D-1:0] s_rdata_o;
  logic [N*I-1:0] s_rid_o;
  logic [N-1:0]   s_rvalid_o;
  logic [N-1:0]   s_rready_i;
  logic [I-1:0]   m_arid_o;
  logic           m_arvalid_o;
  logic           m_arready_i;
  logic [D-1:0]   m_rdata_i;
  logic [I-1:0]   m_rid_i;
  logic           m_rvalid_i;
  logic           m_rready_o;
  logic [I:0]     outstanding_o;
  logic           err_unknown_id_o;

  int n_cmp  = 0;
  int n_fail = 0;

  rob_port_arbiter #(.N_PORTS(N), .DATA_WIDTH(D), .ID_WIDTH(I)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_arid_i         (s_arid_i),
    .s_arvalid_i      (s_arvalid_i),
    .s_arready_o      (s_arready_o),
    .s_rdata_o        (s_rdata_o),
    .s_rid_o          (s_rid_o),
    .s_rvalid_o       (s_rvalid_o),
    .s_rready_i       (s_rready_i),
    .m_arid_o         (m_arid_o),
    .m_arvalid_o      (m_arvalid_o),
    .m_arready_i      (m_arready_i),
    .m_rdata_i        (m_rdata_i),
    .m_rid_i          (m_rid_i),
    .m_rvalid_i       (m_rvalid_i),
    .m_rready_o       (m_rready_o),
    .outstanding_o    (outstanding_o),
    .err_unknown_id_o (err_unknown_id_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven / outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_arid_i    = '0;
    s_arvalid_i = '0;
    s_rready_i  = '1;
    m_arready_i = 1'b1;
    m_rdata_i   = '0;
    m_rid_i     = '0;
    m_rvalid_i  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if (m_arvalid_o !== 1'b0) begin
      $display("FAIL reset_arvalid got=%b exp=0", m_arvalid_o); n_fail++;
    end
    n_cmp++;
    if (m_arid_o !== 4'd0) begin
      $display("FAIL reset_arid got=%0d exp=0", m_arid_o); n_fail++;
    end
    n_cmp++;
    if (outstanding_o !== 5'd0) begin
      $display("FAIL reset_outstanding got=%0d exp=0", outstanding_o); n_fail++;
    end
    n_cmp++;
    if (err_unknown_id_o !== 1'b0) begin
      $display("FAIL reset_err got=%b exp=0", err_unknown_id_o); n_fail++;
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    s_arvalid_i = 4'b0001;
    s_arid_i    = 16'h0005;
    #1;
    n_cmp++;
    if (s_arready_o !== 4'b0001) begin
      $display("FAIL single_arready got=%b exp=0001", s_arready_o); n_fail++;
    end
    tick();
    s_arvalid_i = '0;
    n_cmp++;
    if (m_arvalid_o !== 1'b1 || m_arid_o !== 4'd0) begin
      $display("FAIL single_ar_out got=%b/%0d exp=1/0", m_arvalid_o, m_arid_o); n_fail++;
    end
    n_cmp++;
    if (outstanding_o !== 5'd1) begin
      $display("FAIL single_outstanding got=%0d exp=1", outstanding_o); n_fail++;
    end
    tick();
    m_rvalid_i = 1'b1;
    m_rid_i    = 4'd0;
    m_rdata_i  = 8'h10;
    #1;
    n_cmp++;
    if (s_rvalid_o !== 4'b0001 || s_rid_o[3:0] !== 4'd5 || s_rdata_o[7:0] !== 8'h10) begin
      $display("FAIL single_r got=%b/%0d/%h exp=0001/5/10", s_rvalid_o, s_rid_o[3:0], s_rdata_o[7:0]);
      n_fail++;
    end
    n_cmp++;
    if (m_rready_o !== 1'b1) begin
      $display("FAIL single_rready got=%b exp=1", m_rready_o); n_fail++;
    end
    tick();
    m_rvalid_i = 1'b0;
    n_cmp++;
    if (outstanding_o !== 5'd0) begin
      $display("FAIL single_freed got=%0d exp=0", outstanding_o); n_fail++;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt [5];
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
    exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
    do_reset();
    s_arid_i    = 16'hBA98;  // port p uses local id 8+p
    s_arvalid_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (s_arready_o !== exp_gnt[k]) begin
        $display("FAIL rr_grant%0d got=%b exp=%b", k, s_arready_o, exp_gnt[k]); n_fail++;
      end
      tick();
      n_cmp++;
      if (m_arid_o !== 4'(k) || m_arvalid_o !== 1'b1) begin
        $display("FAIL rr_gid%0d got=%0d exp=%0d", k, m_arid_o, k); n_fail++;
      end
    end
    // Port 0 allocates while global ID 2 (owned by port 2) returns.
    s_arvalid_i = 4'b0001;
    m_rvalid_i  = 1'b1;
    m_rid_i     = 4'd2;
    m_rdata_i   = 8'h5A;
    #1;
    n_cmp++;
    if (s_rvalid_o !== 4'b0100 || s_rid_o[11:8] !== 4'hA || s_rdata_o[23:16] !== 8'h5A) begin
      $display("FAIL rr_route got=%b/%h/%h exp=0100/a/5a", s_rvalid_o, s_rid_o[11:8], s_rdata_o[23:16]);
      n_fail++;
    end
    tick();
    m_rvalid_i = 1'b0;
    n_cmp++;
    if (m_arid_o !== 4'd5 || outstanding_o !== 5'd5) begin
      $display("FAIL rr_simul got=%0d/%0d exp=5/5", m_arid_o, outstanding_o); n_fail++;
    end
    tick();
    s_arvalid_i = '0;
    n_cmp++;
    if (m_arid_o !== 4'd2 || outstanding_o !== 5'd6) begin
      $display("FAIL rr_realloc got=%0d/%0d exp=2/6", m_arid_o, outstanding_o); n_fail++;
    end
  endtask

  task automatic test_full();
    do_reset();
    s_arid_i    = 16'h0030;
    s_arvalid_i = 4'b0010;
    for (int k = 0; k < 16; k++) tick();
    #1;
    n_cmp++;
    if (outstanding_o !== 5'd16) begin
      $display("FAIL full_count got=%0d exp=16", outstanding_o); n_fail++;
    end
    n_cmp++;
    if (s_arready_o !== 4'b0000) begin
      $display("FAIL full_arready got=%b exp=0000", s_arready_o); n_fail++;
    end
    m_rvalid_i = 1'b1;
    m_rid_i    = 4'd7;
    #1;
    n_cmp++;
    if (s_arready_o !== 4'b0000 || s_rvalid_o !== 4'b0010) begin
      $display("FAIL full_free_cycle got=%b/%b exp=0000/0010", s_arready_o, s_rvalid_o); n_fail++;
    end
    tick();
    m_rvalid_i = 1'b0;
    #1;
    n_cmp++;
    if (s_arready_o !== 4'b0010 || outstanding_o !== 5'd15) begin
      $display("FAIL full_reopen got=%b/%0d exp=0010/15", s_arready_o, outstanding_o); n_fail++;
    end
    tick();
    s_arvalid_i = '0;
    n_cmp++;
    if (m_arid_o !== 4'd7 || outstanding_o !== 5'd16) begin
      $display("FAIL full_reuse got=%0d/%0d exp=7/16", m_arid_o, outstanding_o); n_fail++;
    end
  endtask

  task automatic test_r_backpressure();
    do_reset();
    s_arid_i    = 16'h0600;
    s_arvalid_i = 4'b0100;
    for (int k = 0; k < 4; k++) tick();
    s_arvalid_i = '0;
    tick();
    m_rvalid_i = 1'b1;
    m_rid_i    = 4'd3;
    s_rready_i = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (m_rready_o !== 1'b0 || s_rvalid_o !== 4'b0100 || s_rid_o[11:8] !== 4'd6) begin
        $display("FAIL rbp_hold%0d got=%b/%b exp=0/0100", k, m_rready_o, s_rvalid_o); n_fail++;
      end
      tick();
    end
    n_cmp++;
    if (outstanding_o !== 5'd4) begin
      $display("FAIL rbp_kept got=%0d exp=4", outstanding_o); n_fail++;
    end
    s_rready_i = 4'b1111;
    #1;
    n_cmp++;
    if (m_rready_o !== 1'b1) begin
      $display("FAIL rbp_release got=%b exp=1", m_rready_o); n_fail++;
    end
    tick();
    m_rvalid_i = 1'b0;
    n_cmp++;
    if (outstanding_o !== 5'd3) begin
      $display("FAIL rbp_freed got=%0d exp=3", outstanding_o); n_fail++;
    end
  endtask

  task automatic test_unknown_id();
    do_reset();
    m_rvalid_i = 1'b1;
    m_rid_i    = 4'd9;
    #1;
    n_cmp++;
    if (m_rready_o !== 1'b1 || s_rvalid_o !== 4'b0000) begin
      $display("FAIL unk_drop got=%b/%b exp=1/0000", m_rready_o, s_rvalid_o); n_fail++;
    end
    tick();
    m_rvalid_i = 1'b0;
    n_cmp++;
    if (err_unknown_id_o !== 1'b1) begin
      $display("FAIL unk_pulse got=%b exp=1", err_unknown_id_o); n_fail++;
    end
    tick();
    n_cmp++;
    if (err_unknown_id_o !== 1'b0 || outstanding_o !== 5'd0) begin
      $display("FAIL unk_end got=%b/%0d exp=0/0", err_unknown_id_o, outstanding_o); n_fail++;
    end
  endtask

  task automatic test_ar_stall_and_reset();
    do_reset();
    m_arready_i = 1'b0;
    s_arid_i    = 16'h2000;
    s_arvalid_i = 4'b1000;
    #1;
    n_cmp++;
    if (s_arready_o !== 4'b1000) begin
      $display("FAIL stall_first got=%b exp=1000", s_arready_o); n_fail++;
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (s_arready_o !== 4'b0000 || m_arvalid_o !== 1'b1 || m_arid_o !== 4'd0) begin
        $display("FAIL stall_hold%0d got=%b/%b/%0d exp=0000/1/0", k, s_arready_o, m_arvalid_o, m_arid_o);
        n_fail++;
      end
      tick();
    end
    n_cmp++;
    if (outstanding_o !== 5'd1) begin
      $display("FAIL stall_count got=%0d exp=1", outstanding_o); n_fail++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (m_arvalid_o !== 1'b0 || m_arid_o !== 4'd0 || outstanding_o !== 5'd0) begin
      $display("FAIL async_reset got=%b/%0d/%0d exp=0/0/0", m_arvalid_o, m_arid_o, outstanding_o);
      n_fail++;
    end
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_r_backpressure();
    test_unknown_id();
    test_ar_stall_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
